// File: rtl/rx_mac_interface_pkg.sv
// Shared constants, header layout and FSM state encoding for the MAC RX buffer writer.
package rx_mac_interface_pkg;

   localparam int BF           = 7;
   localparam int HDR_LEN_MSB  = 63;
   localparam int HDR_LEN_LSB  = 32;
   localparam int MAX_FRAME_QW = 190;
   localparam int UPD_HOLD_DEF = 4;

   // ts_nsec advances ~6.4 ns per 156.25 MHz clock and restarts every second
   localparam logic [27:0] SEC_TICK_LAST = 28'(156250000 - 1);
   localparam logic [31:0] TS_STEP       = 32'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_DROP = 2'd2
   } rx_state_e;

endpackage

// File: rtl/rx_mac_interface_ptr_sync.sv
// Brings the consumer read pointer into the MAC clock domain and derives free buffer space.
module rx_ptr_sync #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] rd_addr_async,
   input  logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_sync,
   output logic [AW-1:0] free
);

   logic [AW-1:0] rd_meta_q, rd_meta_d;
   logic [AW-1:0] rd_sync_q, rd_sync_d;

   always_comb begin
      rd_meta_d = rd_addr_async;
      rd_sync_d = rd_meta_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_meta_q <= '0;
         rd_sync_q <= '0;
      end else begin
         rd_meta_q <= rd_meta_d;
         rd_sync_q <= rd_sync_d;
      end
   end

   assign rd_sync = rd_sync_q;
   // One slot is kept empty so that equal pointers always mean "buffer empty"
   assign free    = rd_sync_q - wr_ptr - AW'(1);

endmodule

// File: rtl/rx_mac_interface.sv
// MAC RX to circular qword buffer writer: header slot + payload per frame,
// pointer committed only for good frames that fit.
module rx_mac_interface #(
   parameter int AW           = rx_mac_interface_pkg::BF + 1,
   parameter int MAX_FRAME_QW = rx_mac_interface_pkg::MAX_FRAME_QW,
   parameter int UPD_HOLD     = rx_mac_interface_pkg::UPD_HOLD_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [63:0]   rx_data,
   input  logic [7:0]    rx_data_valid,
   input  logic          rx_good_frame,
   input  logic          rx_bad_frame,
   output logic [AW-1:0] wr_addr,
   output logic [63:0]   wr_data,
   output logic          wr_en,
   output logic [AW-1:0] commited_wr_addr,
   output logic          wr_addr_updated,
   input  logic [AW-1:0] commited_rd_addr,
   output logic [31:0]   dropped_frames
);

   import rx_mac_interface_pkg::*;

   localparam int              QW_W      = $clog2(MAX_FRAME_QW + 1);
   localparam int              UW        = $clog2(UPD_HOLD + 1);
   localparam logic [QW_W-1:0] QW_LIMIT  = QW_W'(MAX_FRAME_QW);
   localparam logic [31:0]     FREE_NEED = 32'(MAX_FRAME_QW + 1);
   localparam logic [UW-1:0]   HOLD_LOAD = UW'(UPD_HOLD);

   rx_state_e       state_q, state_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   start_addr_q, start_addr_d;
   logic [AW-1:0]   cur_addr_q, cur_addr_d;
   logic [QW_W-1:0] qw_q, qw_d;
   logic [31:0]     byte_cnt_q, byte_cnt_d;
   logic [31:0]     ts_frame_q, ts_frame_d;
   logic [31:0]     ts_q, ts_d;
   logic [27:0]     tick_q, tick_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [63:0]     wr_data_q, wr_data_d;
   logic [31:0]     dropped_q, dropped_d;
   logic            commit_req_q, commit_req_d;
   logic [AW-1:0]   commit_val_q, commit_val_d;
   logic [AW-1:0]   cwa_q, cwa_d;
   logic            arm_q, arm_d;
   logic [UW-1:0]   upd_cnt_q, upd_cnt_d;
   logic            pend_q, pend_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;

   logic [AW-1:0]   free;
   logic [AW-1:0]   rd_sync;
   logic [31:0]     free32;
   logic [3:0]      popcnt;
   logic            data_in;
   logic [AW-1:0]   frame_end;

   // head_q is the allocation pointer: it moves on the status cycle itself so a
   // back-to-back frame never overlaps, while commited_wr_addr lags behind it.
   rx_ptr_sync #(.AW(AW)) u_ptr_sync (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_addr_async (commited_rd_addr),
      .wr_ptr        (head_q),
      .rd_sync       (rd_sync),
      .free          (free)
   );

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < 8; i++) begin
         popcnt = popcnt + {3'b000, rx_data_valid[i]};
      end
   end

   assign data_in   = (rx_data_valid != 8'h00);
   assign free32    = 32'(free);
   assign frame_end = start_addr_q + AW'(1) + AW'(qw_q);

   always_comb begin
      if (tick_q == SEC_TICK_LAST) begin
         tick_d = '0;
         ts_d   = '0;
      end else begin
         tick_d = tick_q + 28'd1;
         ts_d   = ts_q + TS_STEP;
      end
   end

   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      start_addr_d = start_addr_q;
      cur_addr_d   = cur_addr_q;
      qw_d         = qw_q;
      byte_cnt_d   = byte_cnt_q;
      ts_frame_d   = ts_frame_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      dropped_d    = dropped_q;
      commit_req_d = 1'b0;
      commit_val_d = commit_val_q;

      unique case (state_q)
         S_IDLE: begin
            if (data_in) begin
               if (free32 < FREE_NEED) begin
                  state_d = S_DROP;
               end else begin
                  start_addr_d = head_q;
                  cur_addr_d   = head_q + AW'(2);
                  qw_d         = QW_W'(1);
                  byte_cnt_d   = 32'(popcnt);
                  ts_frame_d   = ts_q;
                  wr_en_d      = 1'b1;
                  wr_addr_d    = head_q + AW'(1);
                  wr_data_d    = rx_data;
                  state_d      = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_good_frame) begin
               wr_en_d                             = 1'b1;
               wr_addr_d                           = start_addr_q;
               wr_data_d[HDR_LEN_MSB:HDR_LEN_LSB]  = byte_cnt_q;
               wr_data_d[HDR_LEN_LSB-1:0]          = ts_frame_q;
               commit_req_d                        = 1'b1;
               commit_val_d                        = frame_end;
               head_d                              = frame_end;
               state_d                             = S_IDLE;
            end else if (rx_bad_frame) begin
               dropped_d = dropped_q + 32'd1;
               state_d   = S_IDLE;
            end else if (data_in) begin
               if (qw_q == QW_LIMIT) begin
                  state_d = S_DROP;
               end else begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = cur_addr_q;
                  wr_data_d  = rx_data;
                  cur_addr_d = cur_addr_q + AW'(1);
                  qw_d       = qw_q + QW_W'(1);
                  byte_cnt_d = byte_cnt_q + 32'(popcnt);
               end
            end
         end
         S_DROP: begin
            if (rx_good_frame || rx_bad_frame) begin
               dropped_d = dropped_q + 32'd1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Commit publication: address first, pulse one cycle later; a commit landing
   // mid-pulse waits in a one-deep slot and re-launches the pulse as it ends.
   logic hold_ending;
   logic pulse_busy;

   always_comb begin
      cwa_d       = cwa_q;
      arm_d       = 1'b0;
      upd_cnt_d   = upd_cnt_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      hold_ending = (upd_cnt_q == UW'(1));
      pulse_busy  = arm_q || ((upd_cnt_q != '0) && !hold_ending);

      if (arm_q) begin
         upd_cnt_d = HOLD_LOAD;
      end else if (upd_cnt_q != '0) begin
         upd_cnt_d = upd_cnt_q - UW'(1);
      end

      if (hold_ending && (pend_q || commit_req_q)) begin
         cwa_d     = commit_req_q ? commit_val_q : pend_addr_q;
         pend_d    = 1'b0;
         upd_cnt_d = HOLD_LOAD;
      end else if (commit_req_q) begin
         if (pulse_busy) begin
            pend_d      = 1'b1;
            pend_addr_d = commit_val_q;
         end else begin
            cwa_d = commit_val_q;
            arm_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         head_q       <= '0;
         start_addr_q <= '0;
         cur_addr_q   <= '0;
         qw_q         <= '0;
         byte_cnt_q   <= '0;
         ts_frame_q   <= '0;
         ts_q         <= '0;
         tick_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         dropped_q    <= '0;
         commit_req_q <= 1'b0;
         commit_val_q <= '0;
         cwa_q        <= '0;
         arm_q        <= 1'b0;
         upd_cnt_q    <= '0;
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         start_addr_q <= start_addr_d;
         cur_addr_q   <= cur_addr_d;
         qw_q         <= qw_d;
         byte_cnt_q   <= byte_cnt_d;
         ts_frame_q   <= ts_frame_d;
         ts_q         <= ts_d;
         tick_q       <= tick_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         dropped_q    <= dropped_d;
         commit_req_q <= commit_req_d;
         commit_val_q <= commit_val_d;
         cwa_q        <= cwa_d;
         arm_q        <= arm_d;
         upd_cnt_q    <= upd_cnt_d;
         pend_q       <= pend_d;
         pend_addr_q  <= pend_addr_d;
      end
   end

   assign wr_en            = wr_en_q;
   assign wr_addr          = wr_addr_q;
   assign wr_data          = wr_data_q;
   assign commited_wr_addr = cwa_q;
   assign wr_addr_updated  = (upd_cnt_q != '0);
   assign dropped_frames   = dropped_q;

endmodule

// File: tb/tb_rx_mac_interface.sv
// Directed bench for rx_mac_interface: frame writes, headers, commits, drops, wrap and reset.
module tb_rx_mac_interface;

   logic        clk;
   logic        reset_n;
   logic [63:0] rx_data;
   logic [7:0]  rx_data_valid;
   logic        rx_good_frame;
   logic        rx_bad_frame;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        wr_en;
   logic [7:0]  commited_wr_addr;
   logic        wr_addr_updated;
   logic [7:0]  commited_rd_addr;
   logic [31:0] dropped_frames;

   int errors = 0;
   int checks = 0;

   logic [7:0]  wa_log[$];
   logic [63:0] wd_log[$];
   int          upd_total = 0;
   int          cyc = 0;
   int          frame_start_cyc = 0;

   rx_mac_interface #(.AW(8), .MAX_FRAME_QW(190), .UPD_HOLD(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .rx_data          (rx_data),
      .rx_data_valid    (rx_data_valid),
      .rx_good_frame    (rx_good_frame),
      .rx_bad_frame     (rx_bad_frame),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .wr_en            (wr_en),
      .commited_wr_addr (commited_wr_addr),
      .wr_addr_updated  (wr_addr_updated),
      .commited_rd_addr (commited_rd_addr),
      .dropped_frames   (dropped_frames)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
      end
      if (wr_addr_updated) upd_total <= upd_total + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called and returns at a negedge with inputs idle; consecutive calls are back-to-back.
   task automatic drive_frame(input int nqw, input logic [7:0] last_v, input int status,
                              input logic [31:0] tag);
      frame_start_cyc = cyc;
      for (int i = 0; i < nqw; i++) begin
         rx_data       = {tag, 32'(i)};
         rx_data_valid = (i == nqw - 1) ? last_v : 8'hFF;
         @(negedge clk);
      end
      rx_data_valid = 8'h00;
      rx_good_frame = (status == 1);
      rx_bad_frame  = (status == 2);
      @(negedge clk);
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rx_data_valid = 8'h00;
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_rd(input logic [7:0] v);
      commited_rd_addr = v;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx_data = 64'hDEAD_BEEF_0123_4567;
      rx_data_valid = 8'h00;
      rx_good_frame = 1'b0;
      rx_bad_frame = 1'b0;
      commited_rd_addr = 8'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_en, wr_addr_updated} !== 2'b00) begin
         errors++; $display("FAIL reset_strobes: got %b required 00", {wr_en, wr_addr_updated});
      end
      checks++;
      if ({wr_addr, commited_wr_addr} !== 16'h0000) begin
         errors++; $display("FAIL reset_addrs: got %h required 0000", {wr_addr, commited_wr_addr});
      end
      checks++;
      if ({wr_data, dropped_frames} !== 96'h0) begin
         errors++; $display("FAIL reset_data: got %h required 0", {wr_data, dropped_frames});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   logic [31:0] ts1;
   int          start1;

   task automatic test_good_64();
      int base = wa_log.size();
      int u0 = upd_total;
      drive_frame(8, 8'hFF, 1, 32'hA000_0001);
      start1 = frame_start_cyc;
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 9) begin
         errors++; $display("FAIL g64_count: got %0d writes required 9", wa_log.size() - base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if ({wa_log[base+i], wd_log[base+i]} !== {8'(i + 1), 32'hA000_0001, 32'(i)}) begin
               errors++; $display("FAIL g64_payload%0d: got %h/%h required %h/%h", i,
                  wa_log[base+i], wd_log[base+i], 8'(i + 1), {32'hA000_0001, 32'(i)});
            end
         end
         checks++;
         if ({wa_log[base+8], wd_log[base+8][63:32]} !== {8'd0, 32'd64}) begin
            errors++; $display("FAIL g64_header: got addr %0d len %0d required addr 0 len 64",
               wa_log[base+8], wd_log[base+8][63:32]);
         end
         ts1 = wd_log[base+8][31:0];
         checks++;
         if ((ts1 % 6) !== 0) begin
            errors++; $display("FAIL g64_ts_step: got %0d required multiple of 6", ts1);
         end
      end
      checks++;
      if (commited_wr_addr !== 8'd9) begin
         errors++; $display("FAIL g64_commit: got %0d required 9", commited_wr_addr);
      end
      checks++;
      if (upd_total - u0 !== 4) begin
         errors++; $display("FAIL g64_upd_pulse: got %0d cycles required 4", upd_total - u0);
      end
   endtask

   task automatic test_good_61();
      int base = wa_log.size();
      logic [31:0] ts2;
      drive_frame(8, 8'h1F, 1, 32'hB000_0002);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 9) begin
         errors++; $display("FAIL g61_count: got %0d writes required 9", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base], wa_log[base+7]} !== {8'd10, 8'd17}) begin
            errors++; $display("FAIL g61_payload_addr: got %0d..%0d required 10..17",
               wa_log[base], wa_log[base+7]);
         end
         checks++;
         if ({wa_log[base+8], wd_log[base+8][63:32]} !== {8'd9, 32'd61}) begin
            errors++; $display("FAIL g61_header: got addr %0d len %0d required addr 9 len 61",
               wa_log[base+8], wd_log[base+8][63:32]);
         end
         ts2 = wd_log[base+8][31:0];
         checks++;
         if (ts2 - ts1 !== 32'(6 * (frame_start_cyc - start1))) begin
            errors++; $display("FAIL g61_ts_delta: got %0d required %0d", ts2 - ts1,
               6 * (frame_start_cyc - start1));
         end
      end
      checks++;
      if (commited_wr_addr !== 8'd18) begin
         errors++; $display("FAIL g61_commit: got %0d required 18", commited_wr_addr);
      end
   endtask

   task automatic test_bad_frame();
      int base = wa_log.size();
      rx_good_frame = 1'b1;
      @(negedge clk);
      rx_good_frame = 1'b0;
      repeat (2) @(negedge clk);
      drive_frame(3, 8'hFF, 2, 32'hC000_0003);
      repeat (8) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 3) begin
         errors++; $display("FAIL bad_count: got %0d writes required 3", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base], wa_log[base+1], wa_log[base+2]} !== {8'd19, 8'd20, 8'd21}) begin
            errors++; $display("FAIL bad_addrs: got %0d %0d %0d required 19 20 21",
               wa_log[base], wa_log[base+1], wa_log[base+2]);
         end
      end
      checks++;
      if ({commited_wr_addr, dropped_frames} !== {8'd18, 32'd1}) begin
         errors++; $display("FAIL bad_commit_drop: got %0d/%0d required 18/1",
            commited_wr_addr, dropped_frames);
      end
      base = wa_log.size();
      drive_frame(1, 8'h01, 1, 32'hC100_0004);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 2) begin
         errors++; $display("FAIL reuse_count: got %0d writes required 2", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base], wa_log[base+1], wd_log[base+1][63:32]} !== {8'd19, 8'd18, 32'd1}) begin
            errors++; $display("FAIL reuse_layout: got %0d %0d len %0d required 19 18 len 1",
               wa_log[base], wa_log[base+1], wd_log[base+1][63:32]);
         end
      end
      checks++;
      if (commited_wr_addr !== 8'd20) begin
         errors++; $display("FAIL reuse_commit: got %0d required 20", commited_wr_addr);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      commited_rd_addr = 8'd0;
      base = wa_log.size();
      for (int f = 0; f < 9; f++) drive_frame(8, 8'hFF, 1, 32'hD000_0000 + 32'(f));
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 72) begin
         errors++; $display("FAIL b2b_count: got %0d writes required 72", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base+71], wd_log[base+71][63:32]} !== {8'd63, 32'd64}) begin
            errors++; $display("FAIL b2b_last_header: got addr %0d len %0d required 63 len 64",
               wa_log[base+71], wd_log[base+71][63:32]);
         end
      end
      checks++;
      if ({commited_wr_addr, dropped_frames} !== {8'd72, 32'd1}) begin
         errors++; $display("FAIL b2b_commit_drop: got %0d/%0d required 72/1",
            commited_wr_addr, dropped_frames);
      end
   endtask

   task automatic test_wrap();
      int base;
      do_reset();
      set_rd(8'd0);
      drive_frame(190, 8'hFF, 1, 32'hE000_0000);
      for (int f = 0; f < 6; f++) begin
         set_rd(8'(191 + 9 * f));
         drive_frame(8, 8'hFF, 1, 32'hE100_0000);
      end
      set_rd(8'd245);
      drive_frame(7, 8'hFF, 1, 32'hE200_0000);
      set_rd(8'd253);
      checks++;
      if (commited_wr_addr !== 8'd253) begin
         errors++; $display("FAIL wrap_setup: got %0d required 253", commited_wr_addr);
      end
      base = wa_log.size();
      drive_frame(8, 8'hFF, 1, 32'hE300_0000);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 9) begin
         errors++; $display("FAIL wrap_count: got %0d writes required 9", wa_log.size() - base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wa_log[base+i] !== 8'(254 + i)) begin
               errors++; $display("FAIL wrap_addr%0d: got %0d required %0d", i,
                  wa_log[base+i], 8'(254 + i));
            end
         end
         checks++;
         if (wa_log[base+8] !== 8'd253) begin
            errors++; $display("FAIL wrap_header: got %0d required 253", wa_log[base+8]);
         end
      end
      checks++;
      if (commited_wr_addr !== 8'd6) begin
         errors++; $display("FAIL wrap_commit: got %0d required 6", commited_wr_addr);
      end
   endtask

   task automatic test_oversize();
      int base;
      int u0;
      logic [31:0] d0;
      set_rd(8'd6);
      base = wa_log.size();
      u0 = upd_total;
      d0 = dropped_frames;
      drive_frame(200, 8'hFF, 1, 32'hF000_0000);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 190) begin
         errors++; $display("FAIL over_count: got %0d writes required 190", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base], wa_log[base+189]} !== {8'd7, 8'd196}) begin
            errors++; $display("FAIL over_addrs: got %0d..%0d required 7..196",
               wa_log[base], wa_log[base+189]);
         end
      end
      checks++;
      if ({commited_wr_addr, dropped_frames} !== {8'd6, d0 + 32'd1}) begin
         errors++; $display("FAIL over_commit_drop: got %0d/%0d required 6/%0d",
            commited_wr_addr, dropped_frames, d0 + 32'd1);
      end
      checks++;
      if (upd_total !== u0) begin
         errors++; $display("FAIL over_no_pulse: got %0d pulse cycles required 0", upd_total - u0);
      end
   endtask

   task automatic test_reset_midframe();
      int base;
      for (int i = 0; i < 3; i++) begin
         rx_data = 64'h1234_0000_0000_0000 + 64'(i);
         rx_data_valid = 8'hFF;
         @(negedge clk);
      end
      reset_n = 1'b0;
      rx_data_valid = 8'h00;
      #1;
      checks++;
      if ({wr_en, wr_addr_updated, wr_addr, commited_wr_addr, dropped_frames} !== 50'h0) begin
         errors++; $display("FAIL midreset_outputs: got en=%b upd=%b addr=%0d cwa=%0d drop=%0d required all 0",
            wr_en, wr_addr_updated, wr_addr, commited_wr_addr, dropped_frames);
      end
      commited_rd_addr = 8'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      base = wa_log.size();
      drive_frame(8, 8'hFF, 1, 32'h5000_0000);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_log.size() - base !== 9) begin
         errors++; $display("FAIL midreset_count: got %0d writes required 9", wa_log.size() - base);
      end else begin
         checks++;
         if ({wa_log[base], wa_log[base+8]} !== {8'd1, 8'd0}) begin
            errors++; $display("FAIL midreset_layout: got first %0d header %0d required 1 and 0",
               wa_log[base], wa_log[base+8]);
         end
      end
      checks++;
      if (commited_wr_addr !== 8'd9) begin
         errors++; $display("FAIL midreset_commit: got %0d required 9", commited_wr_addr);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_good_64();
      test_good_61();
      test_bad_frame();
      test_back_to_back();
      test_wrap();
      test_oversize();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
